// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared state encoding, DDS register map and config check for dds_sequencer
package dds_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } seq_state_t;

  localparam logic [31:0] ADDR_CTRL   = 32'd0;
  localparam logic [31:0] ADDR_THETAS = 32'd1;
  localparam logic [31:0] ADDR_DELTAS = 32'd2;
  localparam logic [31:0] ADDR_AMPLS  = 32'd3;
  localparam logic [31:0] ADDR_CLKDIV = 32'd4;
  localparam logic [31:0] ADDR_STAT   = 32'd5;
  localparam logic [31:0] ADDR_LNGTH  = 32'd6;

  localparam int CTRL_RST  = 0;
  localparam int CTRL_STRT = 1;

  // The sample period must leave room for the DDS to walk every tone plus overhead.
  function automatic logic cfg_valid(input logic [31:0] lngth, input logic [31:0] clkdiv,
                                     input logic [31:0] max_tones);
    logic pow_ok;
    pow_ok = lngth inside {32'd1, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128, 32'd256, 32'd512};
    return pow_ok && (lngth <= max_tones) && ({1'b0, clkdiv} >= ({1'b0, lngth} + 33'd4));
  endfunction

endpackage

// File: rtl/dds_sample_timer.sv
// rtl/dds_sample_timer.sv - free-running period counter with a one-cycle strobe per period
module dds_sample_timer (
  input  logic        clk,
  input  logic        a_rst_n,
  input  logic        en,
  input  logic [31:0] div,
  output logic        o_tick
);

  logic [31:0] cnt;

  // Strobe is registered, so it lands exactly div cycles after en rises.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (cnt == div - 32'd1);
      cnt    <= (cnt == div - 32'd1) ? 32'd0 : cnt + 32'd1;
    end
  end

endmodule

// File: rtl/dds_sequencer.sv
// rtl/dds_sequencer.sv - loads tone triplets into a DDS and paces sample strobes; DDS_SEQ_BURST_EN adds finite bursts
module dds_sequencer
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int MAX_TONES = 512
) (
  input  logic                 clk,
  input  logic                 a_rst_n,
  input  logic                 i_seq_go,
  input  logic                 i_seq_stop,
  input  logic [31:0]          i_lngth,
  input  logic [31:0]          i_clkdiv,
  input  logic                 i_tone_valid,
  output logic                 o_tone_ready,
  input  logic [SIG_WIDTH-1:0] i_tone_theta,
  input  logic [SIG_WIDTH-1:0] i_tone_delta,
  input  logic [SIG_WIDTH-1:0] i_tone_ampl,
  output logic                 o_dds_write,
  output logic [31:0]          o_dds_addrs,
  output logic [SIG_WIDTH-1:0] o_dds_thetas,
  output logic [SIG_WIDTH-1:0] o_dds_deltas,
  output logic [SIG_WIDTH-1:0] o_dds_ampls,
  output logic [31:0]          o_dds_ctrl,
  output logic                 o_dds_sample_en,
  output logic [1:0]           o_state,
  output logic                 o_err,
  input  logic [31:0]          i_burst_len
);

  seq_state_t           state_q, state_d;
  logic [31:0]          lngth_q, clkdiv_q, tone_cnt;
  logic [1:0]           wr_idx;
  logic                 clr_cnt, stop_q, err_q;
  logic                 cfg_ok, go_req, tone_xfer, last_write, sample_en, burst_done;
  logic [SIG_WIDTH-1:0] theta_q, delta_q, ampl_q;

  assign cfg_ok     = cfg_valid(i_lngth, i_clkdiv, 32'(MAX_TONES));
  assign go_req     = i_seq_go && !i_seq_stop;
  assign tone_xfer  = (state_q == S_LOAD) && (wr_idx == 2'd0) && i_tone_valid;
  assign last_write = (wr_idx == 2'd3) && (tone_cnt + 32'd1 == lngth_q);

`ifdef DDS_SEQ_BURST_EN
  logic [31:0] burst_cnt;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n)               burst_cnt <= '0;
    else if (state_q != S_RUN)  burst_cnt <= '0;
    else if (sample_en)         burst_cnt <= burst_cnt + 32'd1;
  end

  assign burst_done = (i_burst_len != 32'd0) && (burst_cnt + 32'd1 == i_burst_len);
`else
  logic unused_burst_len;
  assign unused_burst_len = ^i_burst_len;
  assign burst_done       = 1'b0;
`endif

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_req && cfg_ok) state_d = S_CLEAR;
      S_CLEAR: if (i_seq_stop) state_d = S_IDLE; else if (clr_cnt) state_d = S_LOAD;
      S_LOAD:  if (i_seq_stop) state_d = S_IDLE; else if (last_write) state_d = S_RUN;
      S_RUN:   if (sample_en && (stop_q || burst_done)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      lngth_q  <= '0;
      clkdiv_q <= '0;
      tone_cnt <= '0;
      wr_idx   <= '0;
      clr_cnt  <= 1'b0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      theta_q  <= '0;
      delta_q  <= '0;
      ampl_q   <= '0;
    end else begin
      clr_cnt <= (state_q == S_CLEAR) ? ~clr_cnt : 1'b0;
      stop_q  <= (state_q == S_RUN) && (state_d == S_RUN) && (stop_q || i_seq_stop);
      if (state_q == S_IDLE && go_req) begin
        err_q <= !cfg_ok;
        if (cfg_ok) begin
          lngth_q  <= i_lngth;
          clkdiv_q <= i_clkdiv;
        end
      end
      if (state_q == S_CLEAR)                        tone_cnt <= '0;
      else if (state_q == S_LOAD && wr_idx == 2'd3)  tone_cnt <= tone_cnt + 32'd1;
      // Leaving LOAD for any reason drops whatever is left of the burst.
      if (state_d != S_LOAD) begin
        wr_idx <= 2'd0;
      end else if (tone_xfer) begin
        wr_idx  <= 2'd1;
        theta_q <= i_tone_theta;
        delta_q <= i_tone_delta;
        ampl_q  <= i_tone_ampl;
      end else if (wr_idx != 2'd0) begin
        wr_idx <= wr_idx + 2'd1;
      end
    end
  end

  dds_sample_timer u_timer (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .en      (state_q == S_RUN),
    .div     (clkdiv_q),
    .o_tick  (sample_en)
  );

  always_comb begin
    o_dds_ctrl            = '0;
    o_dds_ctrl[CTRL_RST]  = (state_q == S_CLEAR);
    o_dds_ctrl[CTRL_STRT] = (state_q == S_RUN);
    case (wr_idx)
      2'd1:    o_dds_addrs = ADDR_THETAS;
      2'd2:    o_dds_addrs = ADDR_DELTAS;
      2'd3:    o_dds_addrs = ADDR_AMPLS;
      default: o_dds_addrs = ADDR_CTRL;
    endcase
  end

  assign o_state         = state_q;
  assign o_tone_ready    = (state_q == S_LOAD) && (wr_idx == 2'd0);
  assign o_dds_write     = (wr_idx != 2'd0);
  assign o_dds_thetas    = theta_q;
  assign o_dds_deltas    = delta_q;
  assign o_dds_ampls     = ampl_q;
  assign o_dds_sample_en = sample_en;
  assign o_err           = err_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// tb/tb_dds_sequencer.sv - scoreboard bench for dds_sequencer (DDS_SEQ_BURST_EN selects the burst scenario)
module tb_dds_sequencer;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          i_seq_go = 1'b0, i_seq_stop = 1'b0;
  logic [31:0]   i_lngth = '0, i_clkdiv = '0, i_burst_len = '0;
  logic          i_tone_valid = 1'b0;
  logic          o_tone_ready;
  logic [SW-1:0] i_tone_theta = '0, i_tone_delta = '0, i_tone_ampl = '0;
  logic          o_dds_write;
  logic [31:0]   o_dds_addrs;
  logic [SW-1:0] o_dds_thetas, o_dds_deltas, o_dds_ampls;
  logic [31:0]   o_dds_ctrl;
  logic          o_dds_sample_en;
  logic [1:0]    o_state;
  logic          o_err;

  dds_sequencer #(.SIG_WIDTH(SW), .MAX_TONES(512)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_seq_go(i_seq_go), .i_seq_stop(i_seq_stop),
    .i_lngth(i_lngth), .i_clkdiv(i_clkdiv), .i_tone_valid(i_tone_valid),
    .o_tone_ready(o_tone_ready), .i_tone_theta(i_tone_theta), .i_tone_delta(i_tone_delta),
    .i_tone_ampl(i_tone_ampl), .o_dds_write(o_dds_write), .o_dds_addrs(o_dds_addrs),
    .o_dds_thetas(o_dds_thetas), .o_dds_deltas(o_dds_deltas), .o_dds_ampls(o_dds_ampls),
    .o_dds_ctrl(o_dds_ctrl), .o_dds_sample_en(o_dds_sample_en), .o_state(o_state),
    .o_err(o_err), .i_burst_len(i_burst_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0, n_fail = 0;

  typedef struct {int addr; logic [SW-1:0] data;} wr_t;
  wr_t wr_q[$];
  int  samp_q[$];
  int  writes_left = -1, clkdiv_m = 0, run_start = -1, idle_at = -1, burst_left = -1;
  int  writes_seen = 0, samples_seen = 0;
  bit  stop_armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  wr_t           w;
  logic [SW-1:0] got;
  int            t;

  always @(negedge clk) if (a_rst_n) begin
    if (o_dds_write) begin
      writes_seen++;
      if (wr_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        w = wr_q.pop_front();
        got = (w.addr == 1) ? o_dds_thetas : (w.addr == 2) ? o_dds_deltas : o_dds_ampls;
        check("wr_addr", o_dds_addrs, w.addr);
        check("wr_data", got, w.data);
        if (writes_left > 0) begin
          writes_left--;
          if (writes_left == 0) begin
            run_start = cyc + 1;
            samp_q.push_back(cyc + 1 + clkdiv_m);
          end
        end
      end
    end
    if (run_start == cyc) begin
      check("run_state", o_state, 3);
      check("run_ctrl", o_dds_ctrl, 2);
    end
    if (o_dds_sample_en) begin
      samples_seen++;
      if (samp_q.size() == 0) check("unexpected_sample", 1, 0);
      else begin
        t = samp_q.pop_front();
        check("sample_time", cyc, t);
        if (stop_armed || burst_left == 1) begin
          idle_at = cyc + 1;
          stop_armed = 1'b0;
          burst_left = -1;
        end else begin
          if (burst_left > 1) burst_left--;
          samp_q.push_back(t + clkdiv_m);
        end
      end
    end
    if (idle_at == cyc) begin
      check("exit_idle", o_state, 0);
      idle_at = -1;
    end
  end

  task automatic all_zero(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_ready"}, o_tone_ready, 0);
    check({tag, "_write"}, o_dds_write, 0);
    check({tag, "_ctrl"}, o_dds_ctrl, 0);
    check({tag, "_sample"}, o_dds_sample_en, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_data"}, {o_dds_thetas, o_dds_deltas, o_dds_ampls, o_dds_addrs}, 0);
  endtask

  task automatic go(input int l, input int d);
    i_lngth = l; i_clkdiv = d; run_start = -1; i_seq_go = 1'b1;
    @(posedge clk); #1;
    i_seq_go = 1'b0;
  endtask

  task automatic load_tones(input int n, input bit cont);
    int sent = 0, guard = 0, last_x = -1;
    while (sent < n && guard < 4000) begin
      guard++;
      i_tone_valid = cont || ($urandom_range(0, 2) != 0);
      i_tone_theta = SW'($urandom); i_tone_delta = SW'($urandom); i_tone_ampl = SW'($urandom);
      if (i_tone_valid && o_tone_ready) begin
        wr_q.push_back('{1, i_tone_theta});
        wr_q.push_back('{2, i_tone_delta});
        wr_q.push_back('{3, i_tone_ampl});
        if (cont && last_x >= 0) check("ready_spacing", cyc - last_x, 4);
        last_x = cyc;
        sent++;
      end
      @(posedge clk); #1;
    end
    i_tone_valid = 1'b0;
    if (sent < n) check("load_timeout", sent, n);
  endtask

  task automatic wait_run();
    int g = 0;
    while (!(run_start >= 0 && cyc > run_start) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    check("run_reached", run_start >= 0 && cyc > run_start, 1);
    check("writes_drained", wr_q.size(), 0);
  endtask

  task automatic wait_sample();
    int g = 0;
    @(negedge clk);
    while (!o_dds_sample_en && g < 2000) begin
      @(negedge clk); g++;
    end
    if (!o_dds_sample_en) check("sample_timeout", 0, 1);
  endtask

  task automatic stop_run(input int k);
    wait_sample();
    repeat (k) @(posedge clk);
    #1; i_seq_stop = 1'b1; stop_armed = 1'b1;
    @(posedge clk); #1; i_seq_stop = 1'b0;
    repeat (clkdiv_m + 2) @(posedge clk);
    #1;
    check("stopped_idle", o_state, 0);
    check("no_pending_sample", samp_q.size(), 0);
  endtask

  task automatic quiet_window(input string tag);
    int snap;
    snap = writes_seen;
    i_tone_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1; i_tone_valid = 1'b0;
    check({tag, "_idle"}, o_state, 0);
    check({tag, "_no_writes"}, writes_seen - snap, 0);
  endtask

  initial begin
    #2;
    all_zero("rst");
    repeat (3) @(posedge clk);
    #1; a_rst_n = 1'b1;
    check("idle_after_rst", o_state, 0);

    go(5, 100);
    check("err_lngth5", o_err, 1);
    check("idle_lngth5", o_state, 0);
    go(8, 11);
    check("err_clkdiv11", o_err, 1);
    check("idle_clkdiv11", o_state, 0);

    clkdiv_m = 20; writes_left = 24;
    go(8, 20);
    check("err_cleared", o_err, 0);
    check("clear_state", o_state, 1);
    check("clear_ctrl_a", o_dds_ctrl, 1);
    i_lngth = 5; i_clkdiv = 3;
    @(posedge clk); #1;
    check("clear_ctrl_b", o_dds_ctrl, 1);
    @(posedge clk); #1;
    check("load_state", o_state, 2);
    check("load_ctrl", o_dds_ctrl, 0);
    load_tones(8, 1'b1);
    wait_run();
    repeat (3) wait_sample();
    stop_run(3);

    clkdiv_m = 5; writes_left = 3;
    go(1, 5);
    load_tones(1, 1'b0);
    wait_run();
    stop_run($urandom_range(1, 3));

    clkdiv_m = 40; writes_left = 48;
    go(16, 40);
    load_tones(3, 1'b0);
    i_seq_stop = 1'b1;
    @(posedge clk); #1;
    i_seq_stop = 1'b0; wr_q.delete(); writes_left = -1;
    check("load_stop_idle", o_state, 0);
    quiet_window("load_stop");

    clkdiv_m = 20; writes_left = 24;
    go(8, 20);
    load_tones(2, 1'b1);
    #2; a_rst_n = 1'b0;
    #1; all_zero("mid_rst");
    wr_q.delete(); samp_q.delete(); writes_left = -1; run_start = -1;
    repeat (2) @(posedge clk);
    #1; a_rst_n = 1'b1;
    quiet_window("post_rst");

`ifdef DDS_SEQ_BURST_EN
    begin
      int snap;
      clkdiv_m = 6; writes_left = 3; burst_left = 3; i_burst_len = 3;
      go(1, 6);
      load_tones(1, 1'b0);
      wait_run();
      snap = samples_seen;
      repeat (30) @(posedge clk);
      #1;
      check("burst3_count", samples_seen - snap, 3);
      check("burst3_idle", o_state, 0);
      clkdiv_m = 6; writes_left = 3; burst_left = -1; i_burst_len = 0;
      go(1, 6);
      load_tones(1, 1'b0);
      wait_run();
      repeat (40) @(posedge clk);
      #1;
      check("burst0_running", o_state, 3);
      stop_run(2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dds_sequencer.md
DDS_SEQUENCER -- requirements
Module: dds_sequencer

Interface
REQ-001 SHALL have parameter SIG_WIDTH, default 16, width of theta/delta/ampl words.
REQ-002 SHALL have parameter MAX_TONES, default 512, depth of the tone shift registers.
REQ-003 SHALL have ports: clk input 1 (sole clock); a_rst_n input 1 (asynchronous, active-low reset).
REQ-004 SHALL have ports: i_seq_go input 1 (start request); i_seq_stop input 1 (stop request); i_lngth input 32 (tone count); i_clkdiv input 32 (clocks per output sample).
REQ-005 SHALL have ports: i_tone_valid input 1, o_tone_ready output 1, i_tone_theta/i_tone_delta/i_tone_ampl input SIG_WIDTH each (tone-load handshake).
REQ-006 SHALL have ports: o_dds_write output 1, o_dds_addrs output 32, o_dds_thetas/o_dds_deltas/o_dds_ampls output SIG_WIDTH each (register writes to the DDS).
REQ-007 SHALL have ports: o_dds_ctrl output 32 (bit0 soft reset, bit1 start); o_dds_sample_en output 1 (sample strobe); o_state output 2; o_err output 1 (sticky config error); i_burst_len input 32.

Function
REQ-008 SHALL implement states IDLE=0, CLEAR=1, LOAD=2, RUN=3.
REQ-009 IDLE: o_tone_ready=0, o_dds_ctrl=0; i_seq_go=1 with a valid config -> CLEAR; with an invalid config -> set o_err, stay IDLE.
REQ-010 Valid config: i_lngth in {1,8,16,32,64,128,256,512}, i_lngth<=MAX_TONES, and i_clkdiv>=i_lngth+4.
REQ-011 CLEAR: assert o_dds_ctrl[0] for exactly 2 cycles, clear the tone counter, then -> LOAD.
REQ-012 LOAD: o_tone_ready=1 only when no write burst is pending; a transfer occurs on a cycle with valid&ready.
REQ-013 LOAD: each transfer SHALL issue 3 consecutive o_dds_write pulses with o_dds_addrs 1, 2, 3 carrying the registered theta, delta and ampl; o_tone_ready=0 during the burst.
REQ-014 LOAD: after the i_lngth-th triplet's final write -> RUN on the next cycle.
REQ-015 RUN: o_dds_ctrl[1]=1; the period counter counts 0..i_clkdiv-1 and wraps; o_dds_sample_en=1 for one cycle when the count equals i_clkdiv-1.
REQ-016 The first o_dds_sample_en SHALL occur exactly i_clkdiv cycles after RUN entry.
REQ-017 i_seq_stop in RUN SHALL be latched; exit to IDLE on the cycle after the next o_dds_sample_en (frame completes).
REQ-018 i_seq_stop in CLEAR or LOAD -> IDLE immediately; any partial write burst is abandoned.
REQ-019 i_seq_go and i_seq_stop together SHALL be treated as stop; i_seq_go outside IDLE is ignored.
REQ-020 i_lngth and i_clkdiv SHALL be captured on IDLE->CLEAR; later changes have no effect until the next start.
REQ-021 o_err SHALL clear only on the next accepted i_seq_go.

Reset
REQ-022 a_rst_n=0 SHALL asynchronously force IDLE and clear all counters and latches.
REQ-023 During reset every output SHALL be 0, including o_err, o_dds_sample_en and o_dds_write.
REQ-024 Reset asserted mid-LOAD or mid-RUN SHALL discard all progress; after release the block waits for a new i_seq_go.

Configuration
REQ-025 Macro DDS_SEQ_BURST_EN defined: the block SHALL count o_dds_sample_en pulses in RUN and, when i_burst_len pulses have been emitted (i_burst_len=0 means unlimited), -> IDLE on the next cycle.
REQ-026 Macro DDS_SEQ_BURST_EN undefined: RUN is continuous until stop; i_burst_len is ignored and no burst counter is synthesised.

Structure
REQ-027 A shared package dds_pkg SHALL hold the state enum, the DDS register address constants (CTRL=0, THETAS=1, DELTAS=2, AMPLS=3, CLKDIV=4, STAT=5, LNGTH=6), and the ctrl bit indices RST=0 and STRT=1.
REQ-028 The period counter and strobe SHALL be one sub-module, dds_sample_timer, with ports clk, a_rst_n, en, div and o_tick.

Verification
REQ-029 Config lngth=8, clkdiv=20; go; 8 triplets -> exactly 24 writes at addrs 1,2,3 repeating; RUN entered; sample_en every 20 cycles, first at 20 after RUN entry.
REQ-030 Invalid configs: lngth=5 go -> o_err=1, state stays IDLE; lngth=8, clkdiv=11 go -> o_err=1; a subsequent valid go -> o_err=0.
REQ-031 Stop mid-RUN 3 cycles after a sample_en (clkdiv=20) -> one further sample_en 17 cycles later, IDLE the cycle after it.
REQ-032 Deassert a_rst_n during the 2nd triplet's burst -> all outputs 0 immediately; after release, state IDLE and no writes.
REQ-033 i_tone_valid held high continuously in LOAD -> ready pulses once per 4 cycles (1 transfer + 3 writes); no triplet is lost or duplicated.
REQ-034 With DDS_SEQ_BURST_EN, burst_len=3 -> exactly 3 sample_en pulses, then IDLE; burst_len=0 -> continuous RUN.
